// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 16-bit divider.
//   div_state_e   : divider FSM state encoding
//   DIV_W         : operand/result width
//   DIV_CNT_W     : width of the per-bit step counter
//   DIV_ZERO_QUOT : quotient reported for a zero divisor
package div_pkg;

  localparam int DIV_W     = 16;
  localparam int DIV_CNT_W = $clog2(DIV_W);

  localparam logic [DIV_W-1:0] DIV_ZERO_QUOT = {DIV_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
// The partial remainder is shifted left and the next dividend bit is brought
// in. The divisor is then trial-subtracted on WIDTH+1 bits.
//   rem_in  : current partial remainder (always < divisor)
//   q_msb   : next dividend bit to shift into the remainder
//   divisor : divisor magnitude
//   rem_out : next partial remainder
//   q_bit   : quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic             unused_diff_msb;

  assign shifted = {rem_in, q_msb};
  // One extra bit on top of the WIDTH+1-bit trial so the borrow is explicit.
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  assign borrow  = diff[WIDTH+1];

  // When there is no borrow the difference is below the divisor, so bit WIDTH
  // is always zero. When there is a borrow the shifted value is below the
  // divisor, so its top bit is zero too. Either way WIDTH bits suffice.
  assign unused_diff_msb = diff[WIDTH];

  assign q_bit   = ~borrow;
  assign rem_out = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/div_16b_seq.sv
// Multi-cycle 16-bit integer divider (shift and subtract, one quotient bit per clock).
// The issue stage hands it operands over a valid/ready handshake. The result
// is held until writeback takes it.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake; in_ready is high only while idle
//   dividend, divisor   : operands
//   is_signed           : two's-complement request (used only with DIV_SIGNED_EN)
//   out_valid/out_ready : result handshake
//   quotient, remainder : registered results; they hold their value in IDLE
//   div_by_zero         : the divisor of the presented result was zero
//
// Configuration macro: DIV_SIGNED_EN
//   When it is defined and is_signed=1, both operands are reduced to magnitudes
//   at accept. The signs are reapplied on the final step edge, so the latency
//   does not change.
//   When it is not defined, is_signed is ignored and every divide is unsigned.
//
// State table
//   state | meaning
//   IDLE  | ready for operands, last result held on outputs
//   CALC  | one quotient bit per edge, count runs 0..WIDTH-1
//   DONE  | result presented, waiting for out_ready
//
// Latency: out_valid rises WIDTH edges after the accept edge. For a zero
// divisor it rises on the accept edge itself, so the result is visible in the
// cycle right after the accept cycle.
module div_16b_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dvd_q;     // dividend bits shift out at the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_acc;

  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] dvd_ld;
  logic [WIDTH-1:0] dvs_ld;

  assign accept    = in_valid && (state == IDLE);
  assign last_step = (state == CALC) && (count == LAST);
  assign q_mag     = {dvd_q[WIDTH-2:0], step_qbit};

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_acc),
    .q_msb   (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

`ifdef DIV_SIGNED_EN
  logic sgn_dvd;
  logic sgn_dvs;
  logic neg_q;
  logic neg_r;

  always_comb begin
    sgn_dvd = is_signed & dividend[WIDTH-1];
    sgn_dvs = is_signed & divisor[WIDTH-1];
    // The magnitude of -2^(WIDTH-1) is still correct when it is read as unsigned.
    dvd_ld  = sgn_dvd ? -dividend : dividend;
    dvs_ld  = sgn_dvs ? -divisor  : divisor;
    // Negating 0x8000 gives 0x8000 again, so -32768 / -1 yields quotient 0x8000.
    q_fix   = neg_q ? -q_mag    : q_mag;
    r_fix   = neg_r ? -step_rem : step_rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= sgn_dvd ^ sgn_dvs;
      neg_r <= sgn_dvd;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;

  always_comb begin
    dvd_ld = dividend;
    dvs_ld = divisor;
    q_fix  = q_mag;
    r_fix  = step_rem;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (count == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: operand latch, iteration and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_acc     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      count   <= '0;
      rem_acc <= '0;
      dvd_q   <= dvd_ld;
      dvs_q   <= dvs_ld;
      if (divisor == '0) begin
        // The raw dividend is reported, also for a signed divide.
        quotient    <= DIV_ZERO_QUOT;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      count   <= count + CNT_W'(1);
      rem_acc <= step_rem;
      dvd_q   <= q_mag;
      if (last_step) begin
        quotient    <= q_fix;
        remainder   <= r_fix;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_16b_seq.sv
module tb_div_16b_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int n_vec;
  int n_err;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[$];

  div_16b_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division. In SV, signed division truncates
  // toward zero and the remainder takes the dividend's sign.
  function automatic void ref_div(input logic [15:0] a, input logic [15:0] b, input logic s,
                                  output logic [15:0] q, output logic [15:0] r, output logic dz);
    int   sa;
    int   sb;
    logic unused_s;
    dz = (b == 16'd0);
    if (dz) begin
      q = 16'hFFFF;
      r = a;
      return;
    end
    q = a / b;
    r = a % b;
`ifdef DIV_SIGNED_EN
    if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = 16'(sa / sb);
      r  = 16'(sa % sb);
    end
`else
    unused_s = s;
    sa = 0;
    sb = 0;
`endif
  endfunction

  // Issues one operation and waits for the result. The result is left presented (out_ready=0).
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output logic [15:0] q, output logic [15:0] r, output logic dz,
                          output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL out_valid_timeout: got no out_valid within %0d edges expected one", lat);
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_take", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_take", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic s, input logic [15:0] eq, input logic [15:0] er,
                               input logic edz);
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
    start_op(a, b, s, q, r, dz, lat);
    chk({tag, "_quotient"}, {16'd0, q}, {16'd0, eq});
    chk({tag, "_remainder"}, {16'd0, r}, {16'd0, er});
    chk({tag, "_div_by_zero"}, {31'd0, dz}, {31'd0, edz});
    // 16 edges after accept, or in the cycle right after accept for a zero divisor
    chk({tag, "_latency"}, lat, (b == 16'd0) ? 0 : 16);
    release_result();
  endtask

  initial begin
    logic [15:0] q, r, hq, hr, a, b;
    logic        dz, hdz, s;
    int          lat;
    int          sel;

    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;

    vecs.push_back('{16'd100,   16'd7,     1'b0, 16'd14,    16'd2,    1'b0});
    vecs.push_back('{16'hFFFF,  16'h0001,  1'b0, 16'hFFFF,  16'h0000, 1'b0});
    vecs.push_back('{16'd3,     16'hFFFF,  1'b0, 16'd0,     16'd3,    1'b0});
    vecs.push_back('{16'd5,     16'd0,     1'b0, 16'hFFFF,  16'd5,    1'b1});
    vecs.push_back('{16'd0,     16'd5,     1'b0, 16'd0,     16'd0,    1'b0});
    vecs.push_back('{16'd1234,  16'd1234,  1'b0, 16'd1,     16'd0,    1'b0});
    vecs.push_back('{16'h8000,  16'd2,     1'b0, 16'h4000,  16'd0,    1'b0});
    vecs.push_back('{16'hFFFF,  16'hFFFF,  1'b0, 16'd1,     16'd0,    1'b0});
    vecs.push_back('{16'd60000, 16'd255,   1'b0, 16'd235,   16'd75,   1'b0});
`ifdef DIV_SIGNED_EN
    vecs.push_back('{16'hFFF9,  16'd2,     1'b1, 16'hFFFD,  16'hFFFF, 1'b0});
    vecs.push_back('{16'd7,     16'hFFFE,  1'b1, 16'hFFFD,  16'd1,    1'b0});
    vecs.push_back('{16'h8000,  16'hFFFF,  1'b1, 16'h8000,  16'd0,    1'b0});
    vecs.push_back('{16'hFFF9,  16'd0,     1'b1, 16'hFFFF,  16'hFFF9, 1'b1});
    vecs.push_back('{16'hFFF9,  16'hFFFE,  1'b1, 16'd3,     16'hFFFF, 1'b0});
`else
    // is_signed has no effect in the unsigned-only build
    vecs.push_back('{16'hFFF9,  16'd2,     1'b1, 16'h7FFC,  16'd1,    1'b0});
    vecs.push_back('{16'h8000,  16'hFFFF,  1'b1, 16'd0,     16'h8000, 1'b0});
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_quotient", {16'd0, quotient}, 32'd0);
    chk("reset_remainder", {16'd0, remainder}, 32'd0);
    chk("reset_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                    vecs[i].q, vecs[i].r, vecs[i].dz);
    end

    // Backpressure: the result holds and new operands are ignored while out_ready stays low.
    start_op(16'd1000, 16'd33, 1'b0, hq, hr, hdz, lat);
    chk("bp_quotient", {16'd0, hq}, 32'd30);
    chk("bp_remainder", {16'd0, hr}, 32'd10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 16'd77;
      divisor  = 16'd0;
      @(posedge clk);
      #1;
      chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_result_stable", {quotient, remainder}, {16'd30, 16'd10});
      chk("bp_dz_stable", {31'd0, div_by_zero}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result();
    @(posedge clk);
    #1;
    chk("idle_holds_result", {quotient, remainder}, {16'd30, 16'd10});

    // Reset during CALC at count 8 clears everything right away, and no result appears.
    @(negedge clk);
    dividend  = 16'd50000;
    divisor   = 16'd7;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_calc_busy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_quotient", {16'd0, quotient}, 32'd0);
    chk("rst_mid_remainder", {16'd0, remainder}, 32'd0);
    chk("rst_mid_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_and_check("after_rst", 16'd9, 16'd3, 1'b0, 16'd3, 16'd0, 1'b0);

    // Randomized operations checked against the reference model
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      a   = 16'($urandom);
      s   = 1'($urandom_range(0, 1));
      if (sel == 0)      b = 16'd0;
      else if (sel < 4)  b = 16'($urandom_range(1, 15));
      else if (sel == 4) begin a = 16'h8000; b = 16'hFFFF; end
      else               b = 16'($urandom);
      ref_div(a, b, s, hq, hr, hdz);
      start_op(a, b, s, q, r, dz, lat);
      chk($sformatf("rnd%0d_q(%0h/%0h s%0d)", i, a, b, s), {16'd0, q}, {16'd0, hq});
      chk($sformatf("rnd%0d_r(%0h/%0h s%0d)", i, a, b, s), {16'd0, r}, {16'd0, hr});
      chk($sformatf("rnd%0d_dz", i), {31'd0, dz}, {31'd0, hdz});
      chk($sformatf("rnd%0d_lat", i), lat, (b == 16'd0) ? 0 : 16);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
      end
      release_result();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
